// File: rtl/rr_mux_stream_if.sv
// Stream bundle for rr_mux_stream: N_CH producer channels in, one registered beat out.
// Optional RR_MUX_STREAM_LAST_LOCK_EN adds in_last/out_last packet delimiters.
interface rr_mux_stream_if #(
  parameter int N_CH = 4,
  parameter int W    = 8,
  parameter int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic [N_CH-1:0]   in_valid;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [CW-1:0]     out_ch;
  logic              out_ready;
`ifdef RR_MUX_STREAM_LAST_LOCK_EN
  logic [N_CH-1:0]   in_last;
  logic              out_last;
`endif

  // Mux side: consumes the channel streams and produces the output beat.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ch,
`ifdef RR_MUX_STREAM_LAST_LOCK_EN
    input  in_last,
    output out_last,
`endif
    input  out_ready
  );

  // Environment side: producers and consumer.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ch,
`ifdef RR_MUX_STREAM_LAST_LOCK_EN
    output in_last,
    input  out_last,
`endif
    output out_ready
  );
endinterface

// File: rtl/rr_mux_stream.sv
// Round-robin N_CH:1 valid/ready stream mux with a registered output stage.
// Optional packet lock (hold grant until in_last) enabled by RR_MUX_STREAM_LAST_LOCK_EN.
module rr_mux_stream #(
  parameter int N_CH = 4,
  parameter int W    = 8,
  parameter int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_mux_stream_if.slave bus
);

  localparam int unsigned NCH_U = N_CH;

  logic [CW-1:0]   r_ptr;
  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic [CW-1:0]   r_out_ch;

  logic            w_load_en;
  logic            w_gnt_any;
  logic            w_xfer;
  logic [CW-1:0]   w_gnt_ch;
  logic [CW-1:0]   w_ptr_inc;
  logic [N_CH-1:0] w_elig;
  logic [N_CH-1:0] w_req;
  logic [N_CH-1:0] w_in_ready;
  logic [W-1:0]    w_sel_data;

`ifdef RR_MUX_STREAM_LAST_LOCK_EN
  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } lock_state_t;

  lock_state_t     r_state;
  lock_state_t     w_state_nxt;
  logic [CW-1:0]   r_lock_ch;
  logic [CW-1:0]   w_lock_ch_nxt;
  logic            r_out_last;
  logic            w_sel_last;
`endif

  // Output register may refill on the same edge it drains.
  assign w_load_en = !r_out_valid || bus.out_ready;

  always_comb begin
    w_elig = '1;
`ifdef RR_MUX_STREAM_LAST_LOCK_EN
    if (r_state == ST_LOCKED) begin
      w_elig            = '0;
      w_elig[r_lock_ch] = 1'b1;
    end
`endif
  end

  assign w_req = bus.in_valid & w_elig;

  // First requesting channel at or after the pointer, wrapping modulo N_CH.
  always_comb begin
    logic [CW-1:0] idx;
    idx       = '0;
    w_gnt_any = 1'b0;
    w_gnt_ch  = '0;
    for (int unsigned k = 0; k < NCH_U; k++) begin
      idx = CW'((32'(r_ptr) + k) % NCH_U);
      if (!w_gnt_any && w_req[idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_ch  = idx;
      end
    end
  end

  assign w_xfer    = rst_n && w_load_en && w_gnt_any;
  assign w_ptr_inc = (w_gnt_ch == CW'(N_CH - 1)) ? '0 : w_gnt_ch + 1'b1;

  always_comb begin
    w_sel_data = '0;
    w_in_ready = '0;
`ifdef RR_MUX_STREAM_LAST_LOCK_EN
    w_sel_last = 1'b0;
`endif
    for (int unsigned k = 0; k < NCH_U; k++) begin
      if (w_gnt_ch == CW'(k)) begin
        w_sel_data    = bus.in_data[k*W +: W];
        w_in_ready[k] = w_xfer;
`ifdef RR_MUX_STREAM_LAST_LOCK_EN
        w_sel_last    = bus.in_last[k];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= '0;
`ifdef RR_MUX_STREAM_LAST_LOCK_EN
      r_out_last  <= 1'b0;
`endif
    end else if (w_load_en) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_sel_data;
        r_out_ch   <= w_gnt_ch;
`ifdef RR_MUX_STREAM_LAST_LOCK_EN
        r_out_last <= w_sel_last;
        // While locked the grant is lock_ch, so this lands on lock_ch+1.
        if (w_sel_last) begin
          r_ptr <= w_ptr_inc;
        end
`else
        r_ptr      <= w_ptr_inc;
`endif
      end
    end
  end

`ifdef RR_MUX_STREAM_LAST_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_OPEN;
      r_lock_ch <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_ch <= w_lock_ch_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lock_ch_nxt = r_lock_ch;
    if (w_xfer) begin
      if (w_sel_last) begin
        w_state_nxt = ST_OPEN;
      end else begin
        w_state_nxt   = ST_LOCKED;
        w_lock_ch_nxt = w_gnt_ch;
      end
    end
  end

  assign bus.out_last = r_out_last;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;

endmodule

// File: tb/tb_rr_mux_stream.sv
// Self-checking bench for rr_mux_stream: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural arbitration model.
module tb_rr_mux_stream;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rr_mux_stream_if #(.N_CH(N), .W(W), .CW(CW)) bus ();

  rr_mux_stream #(.N_CH(N), .W(W), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit           m_valid   = 1'b0;
  logic [W-1:0] m_data    = '0;
  int           m_ch      = 0;
  int           m_ptr     = 0;
  bit           m_lock    = 1'b0;
  int           m_lock_ch = 0;
  bit           m_last    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational ready and registered outputs mid-cycle,
  // then advance the model on the rising edge.
  task automatic step();
    bit              ld;
    int              g;
    int              idx;
    logic [N-1:0]    er;
    logic [N*W-1:0]  d;
    @(negedge clk);
    ld = !m_valid || bus.out_ready;
    g  = -1;
    if (rst_n && ld) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && bus.in_valid[idx] && (!m_lock || idx == m_lock_ch)) g = idx;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("in_ready",  32'(bus.in_ready),  32'(er));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("out_data",  32'(bus.out_data),  32'(m_data));
    chk("out_ch",    32'(bus.out_ch),    32'(m_ch));
`ifdef RR_MUX_STREAM_LAST_LOCK_EN
    chk("out_last",  32'(bus.out_last),  32'(m_last));
`endif
    d = bus.in_data;
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0; m_lock = 1'b0; m_last = 1'b0;
    end else if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = d[g*W +: W];
        m_ch    = g;
`ifdef RR_MUX_STREAM_LAST_LOCK_EN
        m_last = bus.in_last[g];
        if (m_last) begin
          m_lock = 1'b0;
          m_ptr  = (g + 1) % N;
        end else begin
          m_lock    = 1'b1;
          m_lock_ch = g;
        end
`else
        m_ptr = (g + 1) % N;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic set_inc_data();
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = W'(8'h10 + i);
  endtask

  initial begin
    int rr_ch [5];
    rr_ch = '{0, 1, 2, 3, 0};

    // Reset with all channels requesting
    rst_n         = 1'b0;
    bus.in_valid  = '1;
    bus.out_ready = 1'b1;
    set_inc_data();
`ifdef RR_MUX_STREAM_LAST_LOCK_EN
    bus.in_last = '1;
`endif
    @(posedge clk); #1;
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);

    // Round-robin with everyone valid
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_ch",   32'(bus.out_ch),   32'(rr_ch[i]));
      chk("rr_data", 32'(bus.out_data), 32'(8'h10 + rr_ch[i]));
    end

    // One more grant (ch1) leaves ptr=2, then sparse 1/3 wraps
    step();
    chk("pre_sparse_ch", 32'(bus.out_ch), 32'd1);
    bus.in_valid = 4'b1010;
    step();
    chk("sparse_ch3", 32'(bus.out_ch), 32'd3);
    step();
    chk("sparse_ch1", 32'(bus.out_ch), 32'd1);
    bus.in_valid = '0;
    step();
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: fill with ch2, stall five cycles
    bus.in_valid = '1;
    step();
    chk("bp_fill_ch", 32'(bus.out_ch), 32'd2);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_ch",   32'(bus.out_ch),   32'd2);
      chk("bp_hold_data", 32'(bus.out_data), 32'h12);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_refill_ch",    32'(bus.out_ch),    32'd3);
    chk("bp_refill_valid", 32'(bus.out_valid), 32'd1);

    // Reset while a beat is held; ptr is 1 beforehand
    step();
    bus.out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("midrst_first_ch", 32'(bus.out_ch), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = N'($urandom);
      bus.in_data   = (N*W)'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst_n         = ($urandom_range(0, 49) != 0);
`ifdef RR_MUX_STREAM_LAST_LOCK_EN
      bus.in_last   = N'($urandom);
`endif
      step();
    end

`ifdef RR_MUX_STREAM_LAST_LOCK_EN
    // Packet lock: ch2 sends three beats while ch0 waits
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = '0;
    set_inc_data();
    step();
    rst_n        = 1'b1;
    bus.in_valid = 4'b0100;
    bus.in_last  = 4'b0000;
    step();
    chk("lock_b1_ch", 32'(bus.out_ch), 32'd2);
    bus.in_valid = 4'b0101;
    step();
    chk("lock_b2_ch",   32'(bus.out_ch),   32'd2);
    chk("lock_b2_last", 32'(bus.out_last), 32'd0);
    bus.in_valid = 4'b0001;
    step();
    chk("lock_bubble", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 4'b0101;
    bus.in_last  = 4'b0100;
    step();
    chk("lock_b3_ch",   32'(bus.out_ch),   32'd2);
    chk("lock_b3_last", 32'(bus.out_last), 32'd1);
    bus.in_valid = 4'b1001;
    bus.in_last  = '1;
    step();
    chk("lock_next_ch3", 32'(bus.out_ch), 32'd3);
    step();
    chk("lock_then_ch0", 32'(bus.out_ch), 32'd0);
`endif

    bus.in_valid = '0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
